// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: MIPS field types, opcode/funct sets and encoder FIFO entry.
package instr_encoder_pkg;
  localparam int SHAM_W = 5;
  localparam int IMM_W = 16;
  localparam int ADDR_W = 26;
  typedef logic [4:0] regbits_t;
  typedef logic [31:0] word_t;
  typedef enum logic [5:0] {
    RTYPE = 6'h00, J = 6'h02, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05,
    ADDI = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A, SLTIU = 6'h0B, ANDI = 6'h0C,
    ORI = 6'h0D, XORI = 6'h0E, LUI = 6'h0F, LW = 6'h23, SW = 6'h2B, HALT = 6'h3F
  } opcode_t;
  typedef enum logic [5:0] {
    SLL = 6'h00, SRL = 6'h02, SRA = 6'h03, JR = 6'h08, ADD = 6'h20, ADDU = 6'h21,
    SUB = 6'h22, SUBU = 6'h23, AND = 6'h24, OR = 6'h25, XOR = 6'h26, NOR = 6'h27,
    SLT = 6'h2A, SLTU = 6'h2B
  } funct_t;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} instr_fmt_t;
  typedef struct packed {
    word_t instr;
    logic  illegal;
  } enc_entry_t;
  function automatic logic op_defined(logic [5:0] o);
    return o inside {RTYPE, J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, HALT};
  endfunction
  function automatic logic funct_defined(logic [5:0] f);
    return f inside {SLL, SRL, SRA, JR, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU};
  endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// encoder_if: decoded-field input stream and encoded-word output stream.
interface encoder_if #(parameter int CNT_W = 16);
  import instr_encoder_pkg::*;
  logic                in_valid;
  logic                in_ready;
  logic [5:0]          op_code;
  logic [5:0]          funct_code;
  regbits_t            rs;
  regbits_t            rt;
  regbits_t            rd;
  logic [SHAM_W-1:0]   shamt;
  logic [IMM_W-1:0]    imm_16;
  logic [ADDR_W-1:0]   imm_26;
  logic                out_valid;
  logic                out_ready;
  word_t               instruction;
  logic                out_illegal;
  logic                err_sticky;
  logic [CNT_W-1:0]    word_cnt;
  modport enc (
    input  in_valid, op_code, funct_code, rs, rt, rd, shamt, imm_16, imm_26, out_ready,
    output in_ready, out_valid, instruction, out_illegal, err_sticky, word_cnt
  );
  modport tb (
    output in_valid, op_code, funct_code, rs, rt, rd, shamt, imm_16, imm_26, out_ready,
    input  in_ready, out_valid, instruction, out_illegal, err_sticky, word_cnt
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: DEPTH-entry FIFO of encoded words with count-based full/empty.
module enc_fifo import instr_encoder_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  enc_entry_t din_i,
  output enc_entry_t dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  enc_entry_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = wp_q + AW'(push_i);
    rp_d = rp_q + AW'(pop_i);
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk_i) if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout_o = mem_q[rp_q];
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS fields into a 32-bit word, buffers it, flags illegal combos.
module instr_encoder import instr_encoder_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST,
  encoder_if.enc bus
);
  instr_fmt_t fmt;
  logic is_halt, is_jr, illegal, push, pop, full, empty, err_q, err_d;
  regbits_t rs_f, rt_f, rd_f;
  logic [SHAM_W-1:0] sh_f;
  logic [IMM_W-1:0] imm_f;
  enc_entry_t entry, head;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    is_halt = bus.op_code == HALT;
    is_jr = bus.op_code == RTYPE && bus.funct_code == JR;
    fmt = bus.op_code == RTYPE ? FMT_R : (bus.op_code == J || bus.op_code == JAL) ? FMT_J : FMT_I;
    rs_f = (bus.op_code == LUI || is_halt) ? '0 : bus.rs;
    rt_f = (is_jr || is_halt) ? '0 : bus.rt;
    rd_f = is_jr ? '0 : bus.rd;
    sh_f = is_jr ? '0 : bus.shamt;
    imm_f = is_halt ? '0 : bus.imm_16;
    entry.instr = fmt == FMT_R ? {bus.op_code, rs_f, rt_f, rd_f, sh_f, bus.funct_code} :
                  fmt == FMT_J ? {bus.op_code, bus.imm_26} : {bus.op_code, rs_f, rt_f, imm_f};
    illegal = !op_defined(bus.op_code) || (bus.op_code == RTYPE && !funct_defined(bus.funct_code));
    entry.illegal = illegal;
    push = bus.in_valid && !full;
    pop = !empty && bus.out_ready;
    err_d = err_q || (push && illegal);
    cnt_d = cnt_q + CNT_W'(pop);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(CLK),
    .rst_i(RST),
    .push_i(push),
    .pop_i(pop),
    .din_i(entry),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  // Outputs read as zero while empty so stale storage never leaks out.
  assign bus.in_ready = !full;
  assign bus.out_valid = !empty;
  assign bus.instruction = empty ? '0 : head.instr;
  assign bus.out_illegal = !empty && head.illegal;
  assign bus.err_sticky = err_q;
  assign bus.word_cnt = cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with scoreboard checking of instr_encoder.
module tb_instr_encoder;
  import instr_encoder_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  encoder_if #(.CNT_W(8)) bus();
  instr_encoder #(.DEPTH(2), .CNT_W(8)) dut (.CLK(CLK), .RST(RST), .bus(bus.enc));
  typedef struct {
    word_t w;
    logic  ill;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  bit stream_on = 1'b0;
  logic [15:0] v;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (!RST) begin
      if (stream_on) chk("no_bubble", 32'(bus.out_valid), 1);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_unexpected observed=%h expected=none", bus.instruction);
        end else begin
          mon_e = q.pop_front();
          chk("sb_word", bus.instruction, mon_e.w);
          chk("sb_illegal", 32'(bus.out_illegal), 32'(mon_e.ill));
        end
      end
    end
  end
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic [4:0] h, input logic [15:0] i16, input logic [25:0] i26,
                      input word_t ew, input logic ei);
    bit done = 1'b0;
    bus.op_code = op;
    bus.funct_code = fn;
    bus.rs = s;
    bus.rt = t;
    bus.rd = d;
    bus.shamt = h;
    bus.imm_16 = i16;
    bus.imm_26 = i26;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        q.push_back('{ew, ei});
        done = 1'b1;
      end
      @(posedge CLK);
    end
    #1;
    bus.in_valid = 1'b0;
    chk("accept", 32'(done), 1);
  endtask
  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge CLK);
      #1;
    end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_code = '0;
    bus.funct_code = '0;
    bus.rs = '0;
    bus.rt = '0;
    bus.rd = '0;
    bus.shamt = '0;
    bus.imm_16 = '0;
    bus.imm_26 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_instruction", bus.instruction, 0);
    chk("rst_out_illegal", 32'(bus.out_illegal), 0);
    chk("rst_err_sticky", 32'(bus.err_sticky), 0);
    chk("rst_word_cnt", 32'(bus.word_cnt), 0);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    send(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221821, 1'b0);
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_word", bus.instruction, 32'h00221821);
    chk("lat_illegal", 32'(bus.out_illegal), 0);
    @(posedge CLK);
    #1;
    chk("word_cnt_1", 32'(bus.word_cnt), 1);
    send(6'h0F, 6'h00, 5'd7, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'h0, 32'h3C04BEEF, 1'b0);
    send(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 32'h0C000100, 1'b0);
    send(6'h00, 6'h08, 5'd31, 5'd5, 5'd6, 5'd3, 16'h0, 26'h0, 32'h03E00008, 1'b0);
    drain();
    chk("word_cnt_4", 32'(bus.word_cnt), 4);
    bus.out_ready = 1'b0;
    send(6'h0D, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h34221234, 1'b0);
    chk("in_ready_partial", 32'(bus.in_ready), 1);
    send(6'h2B, 6'h00, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFC, 26'h0, 32'hAC64FFFC, 1'b0);
    chk("in_ready_full", 32'(bus.in_ready), 0);
    fork
      send(6'h04, 6'h00, 5'd5, 5'd6, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h10A60010, 1'b0);
      begin
        repeat (3) begin
          @(negedge CLK);
          chk("hold_word", bus.instruction, 32'h34221234);
          chk("hold_ready", 32'(bus.in_ready), 0);
        end
        @(posedge CLK);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("word_cnt_7", 32'(bus.word_cnt), 7);
    chk("err_clear", 32'(bus.err_sticky), 0);
    send(6'h3E, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0001, 26'h0, 32'hF8000001, 1'b1);
    chk("err_set", 32'(bus.err_sticky), 1);
    send(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022183F, 1'b1);
    send(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221821, 1'b0);
    drain();
    chk("err_hold", 32'(bus.err_sticky), 1);
    bus.out_ready = 1'b0;
    send(6'h09, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'h0, 32'h24220005, 1'b0);
    send(6'h23, 6'h00, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0008, 26'h0, 32'h8C430008, 1'b0);
    chk("pre_rst_full", 32'(bus.in_ready), 0);
    #1;
    RST = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_instruction", bus.instruction, 0);
    chk("arst_word_cnt", 32'(bus.word_cnt), 0);
    chk("arst_err_sticky", 32'(bus.err_sticky), 0);
    q.delete();
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    chk("post_rst_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    send(6'h3F, 6'h15, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 26'h3FFFFFF, 32'hFC000000, 1'b0);
    drain();
    chk("halt_cnt", 32'(bus.word_cnt), 1);
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 259; i++) begin
      v = 16'(i * 7);
      send(6'h09, 6'h00, v[4:0], v[9:5], 5'd0, 5'd0, v, 26'h0, {6'h09, v[4:0], v[9:5], v}, 1'b0);
      if (i == 0) stream_on = 1'b1;
    end
    stream_on = 1'b0;
    drain();
    chk("word_cnt_wrap", 32'(bus.word_cnt), 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
